// File: rtl/arb_pkg.sv
// Shared constants and request bundle for the sram-like two-master arbiter.
// Master IDs double as the grant ID stored in the in-order response FIFO.
package arb_pkg;

    localparam logic MST_INST = 1'b0;
    localparam logic MST_DATA = 1'b1;

    localparam logic [1:0] SRAM_SIZE_B = 2'd0;
    localparam logic [1:0] SRAM_SIZE_H = 2'd1;
    localparam logic [1:0] SRAM_SIZE_W = 2'd2;

    localparam int SRAM_REQ_W = 1 + 2 + 4 + 32 + 32;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/arb_order_fifo.sv
// In-order grant-ID FIFO: records which master owns each outstanding slave request.
// Latency: dout is the registered head, visible the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module arb_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_like_req_arbiter.sv
// Arbitrates M0 (fetch) / M1 (data) onto one sram-like slave; routes data_ok back in order.
// Latency: zero on both request and response paths. Build option: ARB_ROUND_ROBIN_EN.
// Backpressure: s_req drops at MAX_OUTSTANDING; a stalled grant is locked until s_addr_ok.
module sram_like_req_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    sram_req_t m0_bundle;
    sram_req_t m1_bundle;
    sram_req_t s_bundle;

    logic lock_q;
    logic lock_id_q;
    logic cand_id;
    logic grant_id;
    logic accept;
    logic pop;
    logic head_id;
    logic fifo_full;
    logic fifo_empty;

    assign m0_bundle = '{wr: m0_wr, size: m0_size, wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
    assign m1_bundle = '{wr: m1_wr, size: m1_size, wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};

`ifdef ARB_ROUND_ROBIN_EN
    // rr_q holds the master preferred on the next contended cycle (the one not granted last).
    logic rr_q;

    always_ff @(posedge clk) begin
        if (!resetn)     rr_q <= MST_INST;
        else if (accept) rr_q <= ~grant_id;
    end

    always_comb begin
        cand_id = MST_INST;
        if (m0_req && m1_req) cand_id = rr_q;
        else if (m1_req)      cand_id = MST_DATA;
    end
`else
    always_comb begin
        cand_id = MST_INST;
        if (m1_req) cand_id = MST_DATA;
    end
`endif

    assign grant_id = lock_q ? lock_id_q : cand_id;
    assign s_req    = resetn & (lock_q | m0_req | m1_req) & ~fifo_full;
    assign accept   = s_req & s_addr_ok;

    // Lock freezes s_* from the first unaccepted cycle until the handshake completes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_q    <= 1'b0;
            lock_id_q <= MST_INST;
        end else if (accept) begin
            lock_q    <= 1'b0;
        end else if (s_req) begin
            lock_q    <= 1'b1;
            lock_id_q <= grant_id;
        end
    end

    assign s_bundle = (grant_id == MST_DATA) ? m1_bundle : m0_bundle;
    assign s_wr     = s_bundle.wr;
    assign s_size   = s_bundle.size;
    assign s_wstrb  = s_bundle.wstrb;
    assign s_addr   = s_bundle.addr;
    assign s_wdata  = s_bundle.wdata;

    assign m0_addr_ok = accept & (grant_id == MST_INST);
    assign m1_addr_ok = accept & (grant_id == MST_DATA);

    arb_order_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (grant_id),
        .dout   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // A stray s_data_ok with nothing outstanding is dropped.
    assign pop        = resetn & s_data_ok & ~fifo_empty;
    assign m0_data_ok = pop & (head_id == MST_INST);
    assign m1_data_ok = pop & (head_id == MST_DATA);
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

endmodule
